pool_relu: RTL and testbench

POOL_RELU -- requirements
Module: pool_relu

---
 rtl/pool_relu.sv | 93 +++++++++
 tb/tb_pool_relu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pool_relu.sv
// 2x2 stride-2 max-pooling over a raster-ordered conv result stream.
// Define POOL_RELU_EN to clamp negative samples to zero before pooling.
module pool_relu #(
    parameter logic [7:0] OUT_SIZE = 8'd12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               res_sig,
    input  logic signed [15:0] result,
    input  logic               frame_clr,
    output logic signed [15:0] out_data,
    output logic               out_valid,
    output logic [15:0]        out_addr,
    output logic               done,
    output logic               busy
);

    localparam int HALF = int'(OUT_SIZE) / 2;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [7:0] LAST_POS = OUT_SIZE - 8'd1;

    logic [7:0]         row;
    logic [7:0]         col;
    logic signed [15:0] held;
    logic signed [15:0] line_buf [HALF];
    logic signed [15:0] sample;
    logic signed [15:0] pair;
    logic signed [15:0] pooled;
    logic [IDX_W-1:0]   idx;

    assign idx  = IDX_W'(col >> 1);
    assign busy = (row != 8'd0) || (col != 8'd0);

    // Horizontal pair max, then vertical max against the pair stored on the even row.
    always_comb begin
`ifdef POOL_RELU_EN
        sample = result[15] ? 16'sd0 : result;
`else
        sample = result;
`endif
        pair   = (sample > held) ? sample : held;
        pooled = (pair > line_buf[idx]) ? pair : line_buf[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row       <= 8'd0;
            col       <= 8'd0;
            out_addr  <= 16'd0;
            held      <= 16'sd0;
            out_data  <= 16'sd0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (frame_clr) begin
            row       <= 8'd0;
            col       <= 8'd0;
            out_addr  <= 16'd0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            // Outputs are at least two cycles apart, so the address can advance after each one.
            if (out_valid) begin
                out_addr <= done ? 16'd0 : out_addr + 16'd1;
            end
            if (res_sig) begin
                if (!col[0]) begin
                    held <= sample;
                end
                if (col == LAST_POS) begin
                    col <= 8'd0;
                    row <= (row == LAST_POS) ? 8'd0 : row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
                if (col[0] && row[0]) begin
                    out_data  <= pooled;
                    out_valid <= 1'b1;
                    done      <= (row == LAST_POS) && (col == LAST_POS);
                end
            end
        end
    end

    // Line buffer carries no reset; every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        if (rst_n && !frame_clr && res_sig && col[0] && !row[0]) begin
            line_buf[idx] <= pair;
        end
    end

endmodule

// File: tb/tb_pool_relu.sv
// Directed bench for pool_relu: whole-frame vector table plus clear/reset mid-frame sequences.
module tb_pool_relu;

    localparam int SIZE  = 12;
    localparam int HALF  = SIZE / 2;
    localparam int FRAME = SIZE * SIZE;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               res_sig;
    logic               frame_clr;
    logic signed [15:0] result;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic [15:0]        out_addr;
    logic               done;
    logic               busy;

    always #5 clk = ~clk;

    pool_relu #(.OUT_SIZE(8'd12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_sig   (res_sig),
        .result    (result),
        .frame_clr (frame_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .done      (done),
        .busy      (busy)
    );

    // Each frame is result = base + step*i; pooled output (r,c) is expected to be ek + er*r + ec*c.
    typedef struct {
        int base;
        int step;
        bit stall;
        int ek;
        int er;
        int ec;
    } frame_vec_t;

    frame_vec_t vecs [5];

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    int pos       = 0;
    int cur_k, cur_r, cur_c;

    bit                 pend_on = 1'b0;
    bit                 pend_valid;
    bit                 pend_done;
    bit                 pend_busy;
    logic signed [15:0] pend_data;
    logic signed [15:0] hold_data = 16'sd0;
    logic [15:0]        pend_addr;

    task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        if (pend_on) begin
            checkField("out_valid", {15'd0, out_valid}, {15'd0, pend_valid});
            checkField("done", {15'd0, done}, {15'd0, pend_done});
            checkField("busy", {15'd0, busy}, {15'd0, pend_busy});
            checkField("out_data", out_data, pend_data);
            if (pend_valid) begin
                checkField("out_addr", out_addr, pend_addr);
            end
            if (out_valid === 1'b1 && done === 1'b1) begin
                done_seen++;
            end
        end
    endtask

    // Checks the response to the previous cycle, then drives this cycle and records what it should produce.
    task automatic applyStimulus(input bit rs, input bit clr, input bit rn, input logic signed [15:0] val);
        int r;
        int c;
        @(negedge clk);
        checkOutput();
        res_sig   = rs;
        frame_clr = clr;
        rst_n     = rn;
        result    = val;
        pend_on    = 1'b1;
        pend_valid = 1'b0;
        pend_done  = 1'b0;
        if (!rn) begin
            pos       = 0;
            hold_data = 16'sd0;
        end else if (clr) begin
            pos = 0;
        end else if (rs) begin
            r = pos / SIZE;
            c = pos % SIZE;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                pend_valid = 1'b1;
                pend_addr  = 16'((r / 2) * HALF + c / 2);
                hold_data  = 16'(cur_k + cur_r * (r / 2) + cur_c * (c / 2));
                pend_done  = (pend_addr == 16'(HALF * HALF - 1));
            end
            pos = (pos + 1) % FRAME;
        end
        pend_data = hold_data;
        pend_busy = (pos != 0);
    endtask

    task automatic runSamples(input int n, input int base, input int step, input bit stall);
        for (int i = 0; i < n; i++) begin
            if (stall && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b0, 1'b1, 16'($urandom));
            end
            applyStimulus(1'b1, 1'b0, 1'b1, 16'(base + step * i));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        res_sig   = 1'b0;
        frame_clr = 1'b0;
        result    = 16'sd0;

        vecs[0] = '{0, 1, 1'b0, 13, 24, 2};
`ifdef POOL_RELU_EN
        vecs[1] = '{0, -1, 1'b0, 0, 0, 0};
`else
        vecs[1] = '{0, -1, 1'b0, 0, -24, -2};
`endif
        vecs[2] = '{1000, -1, 1'b0, 1000, -24, -2};
        vecs[3] = '{0, 1, 1'b1, 13, 24, 2};
        vecs[4] = '{0, 1, 1'b0, 13, 24, 2};

        applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'sd77);

        $display("[TB] frame table");
        for (int v = 0; v < 5; v++) begin
            cur_k = vecs[v].ek;
            cur_r = vecs[v].er;
            cur_c = vecs[v].ec;
            runSamples(FRAME, vecs[v].base, vecs[v].step, vecs[v].stall);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'sd0);
        checkField("done_pulses_table", 16'(done_seen), 16'd5);

        $display("[TB] frame_clr at sample 50");
        cur_k = 13;
        cur_r = 24;
        cur_c = 2;
        runSamples(50, 0, 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'sd50);
        runSamples(FRAME, 0, 1, 1'b0);

        $display("[TB] reset at sample 70");
        runSamples(70, 0, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'sd70);
        runSamples(FRAME, 0, 1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'sd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'sd0);
        checkField("done_pulses_total", 16'(done_seen), 16'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
